// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU codes, immediate formats and
// the control/ID-EX bundles used by the decode stage.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  // IMM_R marks formats without an immediate (R-type and unsupported opcodes).
  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4,
    IMM_R = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
    logic       branch;
    logic       jump;
    logic       illegal;
    imm_fmt_e   fmt;
  } ctrl_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
    logic        branch;
    logic        jump;
    logic [2:0]  funct3;
    logic        illegal;
  } idex_t;

  function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'h000};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'h0000_0000;
    endcase
    return imm;
  endfunction

  // alt selects SUB/SRA; callers only raise it where funct7[5] is meaningful.
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_stage_reg_file.sv
// 2-read/1-write architectural register file with x0 tied to zero and
// write-through bypass so a same-cycle write-back is visible to the reader.
module reg_file
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_we,
  input  logic [4:0]      i_wa,
  input  logic [XLEN-1:0] i_wd,
  input  logic [4:0]      i_ra1,
  input  logic [4:0]      i_ra2,
  output logic [XLEN-1:0] o_rd1,
  output logic [XLEN-1:0] o_rd2
);

  logic [XLEN-1:0] r_regs [NREG-1:1];
  logic            w_wr_en;

  assign w_wr_en = i_we && (i_wa != 5'd0);

  // Register storage; x0 has no storage at all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  // Read ports with bypass of the write-back in flight.
  always_comb begin
    o_rd1 = '0;
    o_rd2 = '0;
    if (i_ra1 == 5'd0) begin
      o_rd1 = '0;
    end else if (w_wr_en && (i_wa == i_ra1)) begin
      o_rd1 = i_wd;
    end else begin
      o_rd1 = r_regs[i_ra1];
    end
    if (i_ra2 == 5'd0) begin
      o_rd2 = '0;
    end else if (w_wr_en && (i_wa == i_ra2)) begin
      o_rd2 = i_wd;
    end else begin
      o_rd2 = r_regs[i_ra2];
    end
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: combinational decode and immediate generation feeding a
// registered ID/EX bundle; owns the register file written by write-back.
module id_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_instr,
  input  logic            if_valid,
  input  logic            stall,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [3:0]      ex_alu_op,
  output logic            ex_alu_src,
  output logic            ex_mem_rd,
  output logic            ex_mem_wr,
  output logic            ex_reg_wr,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic [2:0]      ex_funct3,
  output logic            ex_illegal
);

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;
  logic            w_f7b5;
  logic            w_bubble;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;
  ctrl_t           w_ctrl;
  idex_t           w_next;
  idex_t           r_idex;

  assign w_opcode = if_instr[6:0];
  assign w_rd     = if_instr[11:7];
  assign w_funct3 = if_instr[14:12];
  assign w_rs1    = if_instr[19:15];
  assign w_rs2    = if_instr[24:20];
  assign w_f7b5   = if_instr[30];
  assign w_bubble = !if_valid || (if_instr == 32'h0000_0000);

  reg_file #(.XLEN(XLEN), .NREG(NREG)) u_reg_file (
    .clk   (clk),
    .rst   (rst),
    .i_we  (wb_we),
    .i_wa  (wb_rd),
    .i_wd  (wb_data),
    .i_ra1 (w_rs1),
    .i_ra2 (w_rs2),
    .o_rd1 (w_rs1_data),
    .o_rd2 (w_rs2_data)
  );

  // Control decode from opcode/funct fields.
  always_comb begin
    w_ctrl         = '0;
    w_ctrl.alu_op  = ALU_ADD;
    w_ctrl.fmt     = IMM_R;
    case (w_opcode)
      OPC_LUI: begin
        w_ctrl.fmt = IMM_U; w_ctrl.alu_op = ALU_PASSB; w_ctrl.alu_src = 1'b1; w_ctrl.reg_wr = 1'b1;
      end
      OPC_AUIPC: begin
        w_ctrl.fmt = IMM_U; w_ctrl.alu_src = 1'b1; w_ctrl.reg_wr = 1'b1;
      end
      OPC_JAL: begin
        w_ctrl.fmt = IMM_J; w_ctrl.alu_src = 1'b1; w_ctrl.reg_wr = 1'b1; w_ctrl.jump = 1'b1;
      end
      OPC_JALR: begin
        w_ctrl.fmt = IMM_I; w_ctrl.alu_src = 1'b1; w_ctrl.reg_wr = 1'b1; w_ctrl.jump = 1'b1;
      end
      OPC_BRANCH: begin
        w_ctrl.fmt = IMM_B; w_ctrl.alu_op = ALU_SUB; w_ctrl.branch = 1'b1;
      end
      OPC_LOAD: begin
        w_ctrl.fmt = IMM_I; w_ctrl.alu_src = 1'b1; w_ctrl.mem_rd = 1'b1; w_ctrl.reg_wr = 1'b1;
      end
      OPC_STORE: begin
        w_ctrl.fmt = IMM_S; w_ctrl.alu_src = 1'b1; w_ctrl.mem_wr = 1'b1;
      end
      OPC_OPIMM: begin
        // funct7[5] is immediate data except for the shift-right pair.
        w_ctrl.fmt     = IMM_I;
        w_ctrl.alu_op  = alu_from_f3(w_funct3, (w_funct3 == 3'b101) && w_f7b5);
        w_ctrl.alu_src = 1'b1;
        w_ctrl.reg_wr  = 1'b1;
      end
      OPC_OP: begin
        w_ctrl.alu_op = alu_from_f3(w_funct3, w_f7b5);
        w_ctrl.reg_wr = 1'b1;
      end
      default: begin
        w_ctrl.illegal = 1'b1;
      end
    endcase
  end

  // Assemble the next ID/EX contents.
  always_comb begin
    w_next          = '0;
    w_next.valid    = 1'b1;
    w_next.pc       = if_pc;
    w_next.rs1_data = w_rs1_data;
    w_next.rs2_data = w_rs2_data;
    w_next.imm      = imm_gen(if_instr, w_ctrl.fmt);
    w_next.rs1      = w_rs1;
    w_next.rs2      = w_rs2;
    w_next.rd       = w_rd;
    w_next.alu_op   = w_ctrl.alu_op;
    w_next.alu_src  = w_ctrl.alu_src;
    w_next.mem_rd   = w_ctrl.mem_rd;
    w_next.mem_wr   = w_ctrl.mem_wr;
    w_next.reg_wr   = w_ctrl.reg_wr;
    w_next.branch   = w_ctrl.branch;
    w_next.jump     = w_ctrl.jump;
    w_next.funct3   = w_funct3;
    w_next.illegal  = w_ctrl.illegal;
  end

  // ID/EX register: flush beats stall; empty slots load as all-zero bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idex <= '0;
    end else if (flush) begin
      r_idex <= '0;
    end else if (stall) begin
      r_idex <= r_idex;
    end else if (w_bubble) begin
      r_idex <= '0;
    end else begin
      r_idex <= w_next;
    end
  end

  assign ex_valid    = r_idex.valid;
  assign ex_pc       = r_idex.pc;
  assign ex_rs1_data = r_idex.rs1_data;
  assign ex_rs2_data = r_idex.rs2_data;
  assign ex_imm      = r_idex.imm;
  assign ex_rs1      = r_idex.rs1;
  assign ex_rs2      = r_idex.rs2;
  assign ex_rd       = r_idex.rd;
  assign ex_alu_op   = r_idex.alu_op;
  assign ex_alu_src  = r_idex.alu_src;
  assign ex_mem_rd   = r_idex.mem_rd;
  assign ex_mem_wr   = r_idex.mem_wr;
  assign ex_reg_wr   = r_idex.reg_wr;
  assign ex_branch   = r_idex.branch;
  assign ex_jump     = r_idex.jump;
  assign ex_funct3   = r_idex.funct3;
  assign ex_illegal  = r_idex.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: stimulus queues hand-computed ID/EX bundles,
// a monitor compares them one cycle later under a per-field care mask.
module tb_id_stage;

  localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SRA = 4'd7, A_PASSB = 4'd10;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu_op;
    logic        alu_src, mem_rd, mem_wr, reg_wr, branch, jump;
    logic [2:0]  funct3;
    logic        illegal;
  } bun_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] if_pc = 32'h0, if_instr = 32'h0, wb_data = 32'h0;
  logic        if_valid = 1'b0, stall = 1'b0, flush = 1'b0, wb_we = 1'b0;
  logic [4:0]  wb_rd = 5'd0;
  logic        ex_valid, ex_alu_src, ex_mem_rd, ex_mem_wr, ex_reg_wr, ex_branch, ex_jump, ex_illegal;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_alu_op;
  logic [2:0]  ex_funct3;

  id_stage dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid),
    .stall(stall), .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op),
    .ex_alu_src(ex_alu_src), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_reg_wr(ex_reg_wr),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_funct3(ex_funct3), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  bun_t act;
  assign act = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
                ex_alu_op, ex_alu_src, ex_mem_rd, ex_mem_wr, ex_reg_wr, ex_branch, ex_jump,
                ex_funct3, ex_illegal};

  bun_t  exp_q[$];
  bun_t  mask_q[$];
  string name_q[$];
  bun_t  last_e, last_m;
  int    checks = 0, errors = 0;
  logic [31:0] pc = 32'h0000_1000;

  task automatic compare(input string nm, input bun_t e, input bun_t m);
    checks++;
    if (((act ^ e) & m) != '0) begin
      errors++;
      $display("FAIL %s got=%h exp=%h care=%h", nm, act, e, m);
    end
  endtask

  function automatic bun_t mk(input logic [31:0] d1, d2, imm, input logic [4:0] rs1, rs2, rd,
                              input logic [3:0] op, input logic src, mrd, mwr, rwr, br, jmp,
                              input logic [2:0] f3, input logic ill);
    bun_t b;
    b = '0;
    b.valid = 1'b1; b.rs1d = d1; b.rs2d = d2; b.imm = imm;
    b.rs1 = rs1; b.rs2 = rs2; b.rd = rd; b.alu_op = op; b.alu_src = src;
    b.mem_rd = mrd; b.mem_wr = mwr; b.reg_wr = rwr; b.branch = br; b.jump = jmp;
    b.funct3 = f3; b.illegal = ill;
    return b;
  endfunction

  function automatic bun_t msk(input bit c_rs1, c_rs2, c_rd, c_imm, c_src, c_f3, c_op);
    bun_t m;
    m = '1;
    if (!c_rs1) begin m.rs1 = '0; m.rs1d = '0; end
    if (!c_rs2) begin m.rs2 = '0; m.rs2d = '0; end
    if (!c_rd)  m.rd = '0;
    if (!c_imm) m.imm = '0;
    if (!c_src) m.alu_src = 1'b0;
    if (!c_f3)  m.funct3 = '0;
    if (!c_op)  m.alu_op = '0;
    return m;
  endfunction

  task automatic issue(input string nm, input logic [31:0] instr, input logic v, st, fl,
                       input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                       input bun_t e, input bun_t m);
    @(negedge clk);
    rst = 1'b0; if_pc = pc; if_instr = instr; if_valid = v; stall = st; flush = fl;
    wb_we = we; wb_rd = wrd; wb_data = wd;
    if (st && !fl) begin
      e = last_e; m = last_m;
    end else if (e.valid) begin
      e.pc = pc;
    end
    exp_q.push_back(e); mask_q.push_back(m); name_q.push_back(nm);
    last_e = e; last_m = m;
    pc = pc + 32'd4;
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic rst_cycle(input string nm);
    @(negedge clk);
    rst = 1'b1; wb_we = 1'b0; if_valid = 1'b0;
    exp_q.push_back('0); mask_q.push_back('1); name_q.push_back({nm, "_held"});
    last_e = '0; last_m = '1;
    #1 compare({nm, "_async"}, '0, '1);
  endtask

  initial begin : monitor
    bun_t e, m;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front(); m = mask_q.pop_front(); nm = name_q.pop_front();
        compare(nm, e, m);
      end
    end
  end

  initial begin : stimulus
    bun_t z, rr;
    z  = '0;
    rr = msk(1, 1, 1, 0, 1, 1, 1);
    rst_cycle("reset0");
    rst_cycle("reset1");
    for (int i = 1; i < 32; i++)
      issue("fill_bubble", 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 5'(i), 32'h100 + 32'(i), z, '1);
    issue("wb_x0_bypass", 32'h0000_0233, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h1234,
          mk(32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd4, A_ADD, 0, 0, 0, 1, 0, 0, 3'd0, 0), rr);
    issue("read_x0", 32'h0000_0233, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
          mk(32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd4, A_ADD, 0, 0, 0, 1, 0, 0, 3'd0, 0), rr);
    rst_cycle("reset_mid");
    for (int i = 1; i < 32; i++)
      issue("read_cleared", {7'b0, 5'(i), 5'(i), 3'b000, 5'd5, 7'b0110011}, 1'b1, 1'b0, 1'b0,
            1'b0, 5'd0, 32'h0,
            mk(32'h0, 32'h0, 32'h0, 5'(i), 5'(i), 5'd5, A_ADD, 0, 0, 0, 1, 0, 0, 3'd0, 0), rr);
    issue("addi", 32'h0050_0093, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
          mk(32'h0, 32'h0, 32'h5, 5'd0, 5'd0, 5'd1, A_ADD, 1, 0, 0, 1, 0, 0, 3'd0, 0),
          msk(1, 0, 1, 1, 1, 1, 1));
    issue("add_bypass", 32'h0021_01B3, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 32'hDEAD_BEEF,
          mk(32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 5'd2, 5'd2, 5'd3, A_ADD, 0, 0, 0, 1, 0, 0, 3'd0, 0), rr);
    issue("add_stored", 32'h0021_01B3, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
          mk(32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 5'd2, 5'd2, 5'd3, A_ADD, 0, 0, 0, 1, 0, 0, 3'd0, 0), rr);
    issue("beq", 32'hFE00_0CE3, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
          mk(32'h0, 32'h0, 32'hFFFF_FFF8, 5'd0, 5'd0, 5'd0, A_SUB, 0, 0, 0, 0, 1, 0, 3'd0, 0),
          msk(1, 1, 0, 1, 1, 1, 1));
    issue("stall_hold0", 32'h0050_0093, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, z, '1);
    issue("stall_hold1", 32'h0021_01B3, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, z, '1);
    issue("stall_flush", 32'h0050_0093, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, z, '1);
    issue("lw", 32'h0081_2303, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
          mk(32'hDEAD_BEEF, 32'h0, 32'h8, 5'd2, 5'd0, 5'd6, A_ADD, 1, 1, 0, 1, 0, 0, 3'd2, 0),
          msk(1, 0, 1, 1, 1, 1, 1));
    issue("sw", 32'hFE20_2E23, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
          mk(32'h0, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 5'd0, 5'd2, 5'd0, A_ADD, 1, 0, 1, 0, 0, 0, 3'd2, 0),
          msk(1, 1, 0, 1, 1, 1, 1));
    issue("lui", 32'h1234_53B7, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
          mk(32'h0, 32'h0, 32'h1234_5000, 5'd0, 5'd0, 5'd7, A_PASSB, 1, 0, 0, 1, 0, 0, 3'd0, 0),
          msk(0, 0, 1, 1, 1, 0, 1));
    issue("srai", 32'h4041_5413, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
          mk(32'hDEAD_BEEF, 32'h0, 32'h0000_0404, 5'd2, 5'd0, 5'd8, A_SRA, 1, 0, 0, 1, 0, 0, 3'd5, 0),
          msk(1, 0, 1, 1, 1, 1, 1));
    issue("sub", 32'h4021_04B3, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
          mk(32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 5'd2, 5'd2, 5'd9, A_SUB, 0, 0, 0, 1, 0, 0, 3'd0, 0), rr);
    issue("jal", 32'h0100_00EF, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
          mk(32'h0, 32'h0, 32'h0000_0010, 5'd0, 5'd0, 5'd1, A_ADD, 0, 0, 0, 1, 0, 1, 3'd0, 0),
          msk(0, 0, 1, 1, 0, 0, 1));
    issue("illegal", 32'h0000_007F, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,
          mk(32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, A_ADD, 0, 0, 0, 0, 0, 0, 3'd0, 1),
          msk(0, 0, 0, 0, 0, 0, 0));
    issue("invalid_bubble", 32'h0050_0093, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, z, '1);
    issue("idle", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, z, '1);
    for (int t = 0; t < 5 && exp_q.size() != 0; t++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
